// File: rtl/filter_scan_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// filter_scan_ctrl : round-robin debounce scheduler, one shared evaluator for
// N synchronized input lines with HIST-deep sample histories.  Rev 1.0
// ---------------------------------------------------------------------------
module filter_scan_ctrl #(
  parameter int N    = 4,
  parameter int DIV  = 4,
  parameter int HIST = 3,
  localparam int CW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic          flush,
  input  logic [N-1:0]  sig_in,
  output logic [N-1:0]  sig_out,
  output logic          chg,
  output logic [CW-1:0] chg_ch,
  output logic          scan_done,
  output logic          busy
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] C_PRESC_LAST = PW'(DIV - 1);
  localparam logic [CW-1:0] C_CH_LAST    = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_SAMPLE = 2'd2,
    S_EVAL   = 2'd3
  } state_t;

  state_t          r_state;
  logic [N-1:0]    r_sync1;
  logic [N-1:0]    r_sync2;
  logic [HIST-1:0] r_hist [N];
  logic [N-1:0]    r_sig_out;
  logic            r_chg;
  logic [CW-1:0]   r_chg_ch;
  logic            r_scan_done;
  logic [PW-1:0]   r_presc;
  logic [CW-1:0]   r_ch;

  logic            w_all_ones;
  logic            w_all_zeros;

  assign w_all_ones  = &r_hist[r_ch];
  assign w_all_zeros = ~|r_hist[r_ch];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= sig_in;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_sig_out   <= '0;
      r_chg       <= 1'b0;
      r_chg_ch    <= '0;
      r_scan_done <= 1'b0;
      r_presc     <= '0;
      r_ch        <= '0;
      for (int i = 0; i < N; i++) r_hist[i] <= '0;
    end else begin
      r_chg       <= 1'b0;
      r_scan_done <= 1'b0;
      // flush overrides any slot in progress, including a pending EVAL edge
      if (flush) begin
        r_state   <= S_IDLE;
        r_sig_out <= '0;
        r_presc   <= '0;
        r_ch      <= '0;
        for (int i = 0; i < N; i++) r_hist[i] <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_presc <= '0;
            if (enable) r_state <= S_WAIT;
          end
          S_WAIT: begin
            if (!enable) begin
              r_presc <= '0;
              r_state <= S_IDLE;
            end else if (r_presc == C_PRESC_LAST) begin
              r_presc <= '0;
              r_state <= S_SAMPLE;
            end else begin
              r_presc <= r_presc + 1'b1;
            end
          end
          S_SAMPLE: begin
            r_hist[r_ch] <= {r_sync2[r_ch], r_hist[r_ch][HIST-1:1]};
            r_state      <= S_EVAL;
          end
          S_EVAL: begin
            if (w_all_ones && !r_sig_out[r_ch]) begin
              r_sig_out[r_ch] <= 1'b1;
              r_chg           <= 1'b1;
              r_chg_ch        <= r_ch;
            end else if (w_all_zeros && r_sig_out[r_ch]) begin
              r_sig_out[r_ch] <= 1'b0;
              r_chg           <= 1'b1;
              r_chg_ch        <= r_ch;
            end
            if (r_ch == C_CH_LAST) begin
              r_ch        <= '0;
              r_scan_done <= 1'b1;
            end else begin
              r_ch <= r_ch + 1'b1;
            end
            r_state <= enable ? S_WAIT : S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign sig_out   = r_sig_out;
  assign chg       = r_chg;
  assign chg_ch    = r_chg_ch;
  assign scan_done = r_scan_done;
  assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_filter_scan_ctrl.sv
`default_nettype none
// Directed bench for filter_scan_ctrl (N=4, DIV=4, HIST=3); all expected
// cycle counts are relative to the negedge at which the preceding step ended.
module tb_filter_scan_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       flush;
  logic [3:0] sig_in;
  logic [3:0] sig_out;
  logic       chg;
  logic [1:0] chg_ch;
  logic       scan_done;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;
  int n;
  int nchg;

  filter_scan_ctrl #(.N(4), .DIV(4), .HIST(3)) u_dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .flush     (flush),
    .sig_in    (sig_in),
    .sig_out   (sig_out),
    .chg       (chg),
    .chg_ch    (chg_ch),
    .scan_done (scan_done),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // cycles until chg is seen (-1 on timeout)
  task automatic wait_chg(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (chg) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic wait_done(output int cyc, output int chgs);
    cyc  = -1;
    chgs = 0;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (chg) chgs++;
      if (scan_done) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic run_cycles(input int k, output int chgs);
    chgs = 0;
    for (int i = 0; i < k; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (chg) chgs++;
    end
  endtask

  initial begin
    reset  = 1'b0;
    enable = 1'b0;
    flush  = 1'b0;
    sig_in = 4'b0000;
    #2;
    check_val("rst_sig_out", 32'(sig_out), 32'h0);
    check_val("rst_chg", 32'(chg), 32'h0);
    check_val("rst_chg_ch", 32'(chg_ch), 32'h0);
    check_val("rst_scan_done", 32'(scan_done), 32'h0);
    check_val("rst_busy", 32'(busy), 32'h0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    check_val("idle_busy", 32'(busy), 32'h0);
    check_val("idle_sig_out", 32'(sig_out), 32'h0);

    // ch2 held high: set at EVAL of its third visit
    sig_in = 4'b0100;
    enable = 1'b1;
    wait_chg(n);
    check_val("ch2_rise_cyc", 32'(n), 32'd67);
    check_val("ch2_rise_ch", 32'(chg_ch), 32'd2);
    check_val("ch2_rise_out", 32'(sig_out), 32'h4);
    check_val("ch2_rise_done", 32'(scan_done), 32'h0);
    sig_in = 4'b1100;
    @(negedge clock);
    check_val("ch2_chg_width", 32'(chg), 32'h0);

    // ch3 change coincides with the scan wrap
    wait_chg(n);
    check_val("ch3_rise_cyc", 32'(n), 32'd53);
    check_val("ch3_rise_ch", 32'(chg_ch), 32'd3);
    check_val("ch3_rise_done", 32'(scan_done), 32'h1);
    check_val("ch3_rise_out", 32'(sig_out), 32'hC);

    // ch1 rises, then ch2 falls -> 1010
    sig_in = 4'b1010;
    @(negedge clock);
    check_val("ch3_chg_width", 32'(chg), 32'h0);
    wait_chg(n);
    check_val("ch1_rise_cyc", 32'(n), 32'd59);
    check_val("ch1_rise_ch", 32'(chg_ch), 32'd1);
    check_val("ch1_rise_out", 32'(sig_out), 32'hE);
    @(negedge clock);
    check_val("ch1_chg_width", 32'(chg), 32'h0);
    wait_chg(n);
    check_val("ch2_fall_cyc", 32'(n), 32'd5);
    check_val("ch2_fall_ch", 32'(chg_ch), 32'd2);
    check_val("ch2_fall_out", 32'(sig_out), 32'hA);

    // one-scan low glitch on ch1 must be ignored
    sig_in = 4'b1000;
    @(negedge clock);
    check_val("ch2_chg_width", 32'(chg), 32'h0);
    run_cycles(24, nchg);
    sig_in = 4'b1010;
    run_cycles(60, n);
    check_val("glitch_no_chg", 32'(nchg + n), 32'd0);
    check_val("glitch_out", 32'(sig_out), 32'hA);

    // asynchronous reset while in WAIT
    wait_done(n, nchg);
    check_val("pre_rst_done_cyc", 32'(n), 32'd17);
    check_val("pre_rst_busy", 32'(busy), 32'h1);
    check_val("pre_rst_out", 32'(sig_out), 32'hA);
    #1;
    reset  = 1'b0;
    enable = 1'b0;
    #1;
    check_val("arst_sig_out", 32'(sig_out), 32'h0);
    check_val("arst_scan_done", 32'(scan_done), 32'h0);
    check_val("arst_busy", 32'(busy), 32'h0);
    check_val("arst_chg", 32'(chg), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    check_val("post_rst_busy", 32'(busy), 32'h0);
    check_val("post_rst_out", 32'(sig_out), 32'h0);

    // enable dropped during SAMPLE of ch1
    enable = 1'b1;
    repeat (11) @(negedge clock);
    check_val("drop_sample_busy", 32'(busy), 32'h1);
    enable = 1'b0;
    @(negedge clock);
    check_val("drop_eval_busy", 32'(busy), 32'h1);
    @(negedge clock);
    check_val("drop_idle_busy", 32'(busy), 32'h0);
    repeat (4) @(negedge clock);
    check_val("drop_hold_busy", 32'(busy), 32'h0);
    enable = 1'b1;
    wait_done(n, nchg);
    check_val("resume_done_cyc", 32'(n), 32'd13);
    check_val("resume_no_chg", 32'(nchg), 32'd0);

    // flush during EVAL of a pending ch0 set
    sig_in = 4'b1011;
    wait_chg(n);
    check_val("pre_flush_ch1_cyc", 32'(n), 32'd36);
    check_val("pre_flush_ch1_ch", 32'(chg_ch), 32'd1);
    check_val("pre_flush_ch1_out", 32'(sig_out), 32'h2);
    @(negedge clock);
    wait_chg(n);
    check_val("pre_flush_ch3_cyc", 32'(n), 32'd11);
    check_val("pre_flush_ch3_ch", 32'(chg_ch), 32'd3);
    check_val("pre_flush_ch3_done", 32'(scan_done), 32'h1);
    check_val("pre_flush_ch3_out", 32'(sig_out), 32'hA);
    repeat (5) @(negedge clock);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    check_val("flush_sig_out", 32'(sig_out), 32'h0);
    check_val("flush_chg", 32'(chg), 32'h0);
    check_val("flush_scan_done", 32'(scan_done), 32'h0);
    check_val("flush_busy", 32'(busy), 32'h0);
    wait_done(n, nchg);
    check_val("flush_restart_cyc", 32'(n), 32'd25);
    check_val("flush_restart_no_chg", 32'(nchg), 32'd0);
    check_val("flush_restart_out", 32'(sig_out), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
